// File: rtl/isp_pkg.sv
// Shared definitions for the ISP mask back end: coordinate and count widths,
// RGB565 colours, the bounding-box record and the border-hit test.
package isp_pkg;

  localparam int COORD_W = 11;
  localparam int PCNT_W  = 20;

  localparam logic [15:0] RGB565_RED    = 16'hF800;
  localparam logic [15:0] RGB565_GREEN  = 16'h07E0;
  localparam logic [15:0] RGB565_BLUE   = 16'h001F;
  localparam logic [15:0] BOX_COLOR_DEF = RGB565_RED;

  typedef struct packed {
    logic [COORD_W-1:0] x_min;
    logic [COORD_W-1:0] x_max;
    logic [COORD_W-1:0] y_min;
    logic [COORD_W-1:0] y_max;
  } box_t;

  // True when (x, y) sits on the outline of box b; a 1x1 box outlines its single pixel.
  function automatic logic on_border(input box_t b,
                                     input logic [COORD_W-1:0] x,
                                     input logic [COORD_W-1:0] y);
    logic in_x;
    logic in_y;
    logic on_x;
    logic on_y;
    in_x = (x >= b.x_min) && (x <= b.x_max);
    in_y = (y >= b.y_min) && (y <= b.y_max);
    on_x = (x == b.x_min) || (x == b.x_max);
    on_y = (y == b.y_min) || (y == b.y_max);
    return (on_x && in_y) || (on_y && in_x);
  endfunction

endpackage

// File: rtl/isp_1bit_bbox_if.sv
// Pixel-stream bundle between the dilation stage, the bounding-box block and
// the display write path.
interface isp_1bit_bbox_if;
  import isp_pkg::*;

  logic               wr_en;
  logic               img_1bit_in;
  logic [15:0]        pix_data_in;
  logic               box_wr_en;
  logic [15:0]        box_data;
  logic               box_valid;
  logic [COORD_W-1:0] x_min;
  logic [COORD_W-1:0] x_max;
  logic [COORD_W-1:0] y_min;
  logic [COORD_W-1:0] y_max;
  logic               frame_done;

  modport master (
    output wr_en, img_1bit_in, pix_data_in,
    input  box_wr_en, box_data, box_valid, x_min, x_max, y_min, y_max, frame_done
  );

  modport slave (
    input  wr_en, img_1bit_in, pix_data_in,
    output box_wr_en, box_data, box_valid, x_min, x_max, y_min, y_max, frame_done
  );

endinterface

// File: rtl/isp_1bit_bbox_acc.sv
// Pixel position counters and per-frame foreground accumulators; presents the
// box and count including the current pixel together with the end-of-frame strobe.
module isp_bbox_acc
  import isp_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               frame_rst,
  input  logic               wr_en,
  input  logic               img_1bit_in,
  output logic [COORD_W-1:0] x_cnt,
  output logic [COORD_W-1:0] y_cnt,
  output logic               commit,
  output box_t               acc_box,
  output logic [PCNT_W-1:0]  acc_cnt
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);

  logic [COORD_W-1:0] x_cnt_r;
  logic [COORD_W-1:0] y_cnt_r;
  logic               hit_r;
  box_t               box_r;
  logic [PCNT_W-1:0]  pix_cnt_r;

  logic               hit_px_s;
  logic               last_s;
  logic               commit_s;
  box_t               box_nxt_s;
  logic [PCNT_W-1:0]  cnt_nxt_s;

  // Fold the current pixel into the box and count; the first hit seeds all four edges.
  always_comb begin
    hit_px_s  = wr_en && img_1bit_in && !frame_rst;
    last_s    = (x_cnt_r == X_LAST) && (y_cnt_r == Y_LAST);
    commit_s  = wr_en && !frame_rst && last_s;
    box_nxt_s = box_r;
    cnt_nxt_s = pix_cnt_r;
    if (hit_px_s) begin
      if (!hit_r) begin
        box_nxt_s = '{x_min: x_cnt_r, x_max: x_cnt_r, y_min: y_cnt_r, y_max: y_cnt_r};
      end else begin
        box_nxt_s.x_min = (x_cnt_r < box_r.x_min) ? x_cnt_r : box_r.x_min;
        box_nxt_s.x_max = (x_cnt_r > box_r.x_max) ? x_cnt_r : box_r.x_max;
        box_nxt_s.y_min = (y_cnt_r < box_r.y_min) ? y_cnt_r : box_r.y_min;
        box_nxt_s.y_max = (y_cnt_r > box_r.y_max) ? y_cnt_r : box_r.y_max;
      end
      cnt_nxt_s = (pix_cnt_r == {PCNT_W{1'b1}}) ? pix_cnt_r : pix_cnt_r + PCNT_W'(1);
    end else begin
      box_nxt_s = box_r;
      cnt_nxt_s = pix_cnt_r;
    end
  end

  // Position counters and accumulators; a commit or frame restart empties the accumulators.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x_cnt_r   <= '0;
      y_cnt_r   <= '0;
      hit_r     <= 1'b0;
      box_r     <= '0;
      pix_cnt_r <= '0;
    end else if (frame_rst) begin
      x_cnt_r   <= '0;
      y_cnt_r   <= '0;
      hit_r     <= 1'b0;
      box_r     <= '0;
      pix_cnt_r <= '0;
    end else if (wr_en) begin
      if (x_cnt_r == X_LAST) begin
        x_cnt_r <= '0;
        y_cnt_r <= (y_cnt_r == Y_LAST) ? '0 : y_cnt_r + COORD_W'(1);
      end else begin
        x_cnt_r <= x_cnt_r + COORD_W'(1);
      end
      if (commit_s) begin
        hit_r     <= 1'b0;
        box_r     <= '0;
        pix_cnt_r <= '0;
      end else begin
        hit_r     <= hit_r || hit_px_s;
        box_r     <= box_nxt_s;
        pix_cnt_r <= cnt_nxt_s;
      end
    end
  end

  assign x_cnt   = x_cnt_r;
  assign y_cnt   = y_cnt_r;
  assign commit  = commit_s;
  assign acc_box = box_nxt_s;
  assign acc_cnt = cnt_nxt_s;

endmodule

// File: rtl/isp_1bit_bbox.sv
// Foreground bounding-box tracker: commits one box per frame and draws the
// previously committed box as a coloured outline over the display stream.
module isp_1bit_bbox
  import isp_pkg::*;
#(
  parameter int          IMG_W      = 640,
  parameter int          IMG_H      = 480,
  parameter int          MIN_PIXELS = 64,
  parameter logic [15:0] BOX_COLOR  = BOX_COLOR_DEF
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  input  logic           frame_rst,
  isp_1bit_bbox_if.slave bus
);

  logic [COORD_W-1:0] x_cnt_s;
  logic [COORD_W-1:0] y_cnt_s;
  logic               commit_s;
  box_t               acc_box_s;
  logic [PCNT_W-1:0]  acc_cnt_s;

  logic               box_wr_en_r;
  logic [15:0]        box_data_r;
  logic               box_valid_r;
  box_t               box_r;
  logic               frame_done_r;

  logic               draw_s;
  logic               min_ok_s;
  logic [15:0]        data_nxt_s;

  isp_bbox_acc #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_acc (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .frame_rst   (frame_rst),
    .wr_en       (bus.wr_en),
    .img_1bit_in (bus.img_1bit_in),
    .x_cnt       (x_cnt_s),
    .y_cnt       (y_cnt_s),
    .commit      (commit_s),
    .acc_box     (acc_box_s),
    .acc_cnt     (acc_cnt_s)
  );

  // Overlay decision; a pixel swallowed by frame_rst always passes through untouched.
  always_comb begin
    min_ok_s = (acc_cnt_s >= PCNT_W'(MIN_PIXELS));
    if (bus.wr_en && !frame_rst && box_valid_r) begin
      draw_s = on_border(box_r, x_cnt_s, y_cnt_s);
    end else begin
      draw_s = 1'b0;
    end
    if (!bus.wr_en) begin
      data_nxt_s = 16'h0000;
    end else if (draw_s) begin
      data_nxt_s = BOX_COLOR;
    end else begin
      data_nxt_s = bus.pix_data_in;
    end
  end

  // Output pixel stage plus committed box; coordinates only move on a qualifying frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      box_wr_en_r  <= 1'b0;
      box_data_r   <= 16'h0000;
      box_valid_r  <= 1'b0;
      box_r        <= '0;
      frame_done_r <= 1'b0;
    end else begin
      box_wr_en_r  <= bus.wr_en;
      box_data_r   <= data_nxt_s;
      frame_done_r <= commit_s;
      if (commit_s) begin
        box_valid_r <= min_ok_s;
        box_r       <= min_ok_s ? acc_box_s : box_r;
      end
    end
  end

  assign bus.box_wr_en  = box_wr_en_r;
  assign bus.box_data   = box_data_r;
  assign bus.box_valid  = box_valid_r;
  assign bus.x_min      = box_r.x_min;
  assign bus.x_max      = box_r.x_max;
  assign bus.y_min      = box_r.y_min;
  assign bus.y_max      = box_r.y_max;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_isp_1bit_bbox.sv
// Bench for isp_1bit_bbox: two instances (MIN_PIXELS 2 and 1) on an 8x4 image,
// driven identically and checked every cycle against a frame-level model.
module tb_isp_1bit_bbox;

  localparam int W = 8;
  localparam int H = 4;
  localparam logic [15:0] BOX = 16'hF800;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_rst = 1'b0;

  isp_1bit_bbox_if if2 ();
  isp_1bit_bbox_if if1 ();

  isp_1bit_bbox #(.IMG_W(W), .IMG_H(H), .MIN_PIXELS(2), .BOX_COLOR(BOX)) dut2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .frame_rst(frame_rst), .bus(if2));
  isp_1bit_bbox #(.IMG_W(W), .IMG_H(H), .MIN_PIXELS(1), .BOX_COLOR(BOX)) dut1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .frame_rst(frame_rst), .bus(if1));

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  // reference model: committed boxes per instance, this frame's foreground list, position
  int minp[2] = '{2, 1};
  int cvalid[2];
  int cxmin[2];
  int cxmax[2];
  int cymin[2];
  int cymax[2];
  int fx[$];
  int fy[$];
  int px = 0;
  int py = 0;
  bit mask[0:W*H-1];
  bit fix_data = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit border_m(input int i, input int x, input int y);
    bit on_col = (x == cxmin[i]) || (x == cxmax[i]);
    bit on_row = (y == cymin[i]) || (y == cymax[i]);
    bit in_col = (x >= cxmin[i]) && (x <= cxmax[i]);
    bit in_row = (y >= cymin[i]) && (y <= cymax[i]);
    return (on_col && in_row) || (on_row && in_col);
  endfunction

  task automatic commit_m();
    int n = fx.size();
    for (int i = 0; i < 2; i++) begin
      if (n >= minp[i]) begin
        cvalid[i] = 1;
        cxmin[i] = W; cxmax[i] = -1; cymin[i] = H; cymax[i] = -1;
        for (int k = 0; k < n; k++) begin
          if (fx[k] < cxmin[i]) cxmin[i] = fx[k];
          if (fx[k] > cxmax[i]) cxmax[i] = fx[k];
          if (fy[k] < cymin[i]) cymin[i] = fy[k];
          if (fy[k] > cymax[i]) cymax[i] = fy[k];
        end
      end else begin
        cvalid[i] = 0;
      end
    end
    fx.delete();
    fy.delete();
  endtask

  task automatic check_all(input bit e_we, input logic [15:0] e2, input logic [15:0] e1, input bit e_done);
    chk("d2.box_wr_en", if2.box_wr_en, e_we);
    chk("d2.box_data", if2.box_data, e2);
    chk("d2.frame_done", if2.frame_done, e_done);
    chk("d2.box_valid", if2.box_valid, cvalid[0]);
    chk("d2.x_min", if2.x_min, cxmin[0]);
    chk("d2.x_max", if2.x_max, cxmax[0]);
    chk("d2.y_min", if2.y_min, cymin[0]);
    chk("d2.y_max", if2.y_max, cymax[0]);
    chk("d1.box_wr_en", if1.box_wr_en, e_we);
    chk("d1.box_data", if1.box_data, e1);
    chk("d1.frame_done", if1.frame_done, e_done);
    chk("d1.box_valid", if1.box_valid, cvalid[1]);
    chk("d1.x_min", if1.x_min, cxmin[1]);
    chk("d1.x_max", if1.x_max, cxmax[1]);
    chk("d1.y_min", if1.y_min, cymin[1]);
    chk("d1.y_max", if1.y_max, cymax[1]);
  endtask

  // one clock of stimulus; expected overlay uses the box committed before this pixel
  task automatic drive(input bit we, input bit fg, input bit frst);
    logic [15:0] d;
    logic [15:0] e[2];
    bit e_done = 1'b0;
    d = fix_data ? 16'h1234 : 16'($urandom);
    if2.wr_en = we; if2.img_1bit_in = fg; if2.pix_data_in = d;
    if1.wr_en = we; if1.img_1bit_in = fg; if1.pix_data_in = d;
    frame_rst = frst;
    for (int i = 0; i < 2; i++)
      e[i] = !we ? 16'h0000 : (!frst && cvalid[i] != 0 && border_m(i, px, py)) ? BOX : d;
    if (frst) begin
      fx.delete(); fy.delete(); px = 0; py = 0;
    end else if (we) begin
      if (fg) begin fx.push_back(px); fy.push_back(py); end
      if (px == W-1 && py == H-1) begin commit_m(); e_done = 1'b1; end
      if (px == W-1) begin px = 0; py = (py == H-1) ? 0 : py + 1; end
      else px++;
    end
    @(posedge clk);
    #1;
    check_all(we, e[0], e[1], e_done);
  endtask

  // one frame from the mask; gap<0 gives random gaps; stops after a frame_rst at index rst_at
  task automatic run_frame(input int gap, input int rst_at);
    for (int p = 0; p < W*H; p++) begin
      if (p == rst_at) begin
        drive(1'b1, mask[p], 1'b1);
        return;
      end
      drive(1'b1, mask[p], 1'b0);
      repeat ((gap < 0) ? $urandom_range(0, 2) : gap) drive(1'b0, 1'($urandom), 1'b0);
    end
  endtask

  task automatic set_mask(input int a, input int b);
    for (int p = 0; p < W*H; p++) mask[p] = 1'b0;
    if (a >= 0) mask[a] = 1'b1;
    if (b >= 0) mask[b] = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      cvalid[i] = 0; cxmin[i] = 0; cxmax[i] = 0; cymin[i] = 0; cymax[i] = 0;
    end
    if2.wr_en = 1'b1; if2.img_1bit_in = 1'b1; if2.pix_data_in = 16'hBEEF;
    if1.wr_en = 1'b1; if1.img_1bit_in = 1'b1; if1.pix_data_in = 16'hBEEF;
    repeat (3) @(posedge clk);
    #1;
    check_all(1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

    // all-zero mask, constant data: pure passthrough, one frame_done, no box
    fix_data = 1'b1;
    set_mask(-1, -1);
    run_frame(0, -1);
    fix_data = 1'b0;
    drive(1'b0, 1'b0, 1'b0);

    // foreground at (2,1) and (5,2), then an empty frame carrying the overlay
    set_mask(1*W+2, 2*W+5);
    run_frame(0, -1);
    chk("t2.x_min", if2.x_min, 2);
    chk("t2.x_max", if2.x_max, 5);
    chk("t2.y_min", if2.y_min, 1);
    chk("t2.y_max", if2.y_max, 2);
    chk("t2.valid", if2.box_valid, 1);
    set_mask(-1, -1);
    run_frame(0, -1);

    // single pixel: too few for MIN_PIXELS=2, a 1x1 box for MIN_PIXELS=1
    set_mask(2*W+4, -1);
    run_frame(0, -1);
    chk("t3.valid", if2.box_valid, 0);
    chk("t3.x_min_kept", if2.x_min, 2);
    chk("t3.x_1x1", if1.x_max, 4);
    set_mask(-1, -1);
    run_frame(0, -1);

    // foreground only on the very last pixel
    set_mask(W*H-1, -1);
    run_frame(0, -1);
    chk("t4.x_min", if1.x_min, 7);
    chk("t4.y_max", if1.y_max, 3);
    set_mask(-1, -1);
    run_frame(0, -1);

    // commit a box in both, then abort a frame with frame_rst, then an empty frame
    set_mask(1*W+1, 3*W+6);
    run_frame(0, -1);
    set_mask(0, 1);
    run_frame(0, 5);
    drive(1'b0, 1'b0, 1'b1);
    set_mask(-1, -1);
    run_frame(0, -1);
    chk("t5.valid", if2.box_valid, 0);

    // gapped stream, 1 on / 2 off
    set_mask(1*W+2, 2*W+5);
    run_frame(2, -1);
    set_mask(-1, -1);
    run_frame(2, -1);

    // random masks, random gaps, occasional frame restarts
    for (int f = 0; f < 12; f++) begin
      int dens = (f % 3 == 0) ? 31 : 3;
      for (int p = 0; p < W*H; p++) mask[p] = ($urandom_range(0, dens) == 0);
      run_frame(-1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W*H-1)) : -1);
    end
    drive(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
